// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, fetch lookup, decode-feedback training and mispredict redirect
module branch_predictor #(
  parameter int PC_SIZE    = 16,
  parameter int INDEX_BITS = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [PC_SIZE-1:0]   i_lookup_pc,
  output logic                 o_predict_taken,
  output logic [PC_SIZE-1:0]   o_predict_target,
  output logic                 o_predict_hit,
  input  logic                 i_fb_valid,
  input  logic                 i_fb_branch,
  input  logic [PC_SIZE-1:0]   i_fb_pc,
  input  logic                 i_fb_predict_taken,
  input  logic [PC_SIZE-1:0]   i_fb_predict_target,
  input  logic                 i_fb_feedback_taken,
  input  logic [PC_SIZE-1:0]   i_fb_feedback_target,
  output logic                 o_mispredict,
  output logic [PC_SIZE-1:0]   o_redirect_pc,
  output logic [CNT_WIDTH-1:0] o_branch_count,
  output logic [CNT_WIDTH-1:0] o_mispredict_count
);
  localparam int N  = 2 ** INDEX_BITS;
  localparam int TW = PC_SIZE - INDEX_BITS;
  logic                 r_valid  [N];
  logic [TW-1:0]        r_tag    [N];
  logic [PC_SIZE-1:0]   r_target [N];
  logic [1:0]           r_ctr    [N];
  logic [CNT_WIDTH-1:0] r_bcnt, r_mcnt;
  logic [INDEX_BITS-1:0] w_li, w_fi;
  logic [TW-1:0]        w_lt, w_ft;
  logic                 w_hit, w_fb_hit, w_mis_br;
  assign w_li = i_lookup_pc[INDEX_BITS-1:0];
  assign w_lt = i_lookup_pc[PC_SIZE-1:INDEX_BITS];
  assign w_fi = i_fb_pc[INDEX_BITS-1:0];
  assign w_ft = i_fb_pc[PC_SIZE-1:INDEX_BITS];
  assign w_hit    = r_valid[w_li] && r_tag[w_li] == w_lt;
  assign w_fb_hit = r_valid[w_fi] && r_tag[w_fi] == w_ft;
  assign o_predict_hit    = w_hit;
  assign o_predict_taken  = w_hit && r_ctr[w_li][1];
  assign o_predict_target = o_predict_taken ? r_target[w_li] : i_lookup_pc + 1'b1;
  assign w_mis_br = (i_fb_predict_taken != i_fb_feedback_taken) ||
                    (i_fb_predict_taken && i_fb_feedback_taken && i_fb_predict_target != i_fb_feedback_target);
  assign o_mispredict  = i_fb_valid && (i_fb_branch ? w_mis_br : i_fb_predict_taken);
  assign o_redirect_pc = (o_mispredict && i_fb_branch && i_fb_feedback_taken) ? i_fb_feedback_target
                                                                              : i_fb_pc + 1'b1;
  assign o_branch_count     = r_bcnt;
  assign o_mispredict_count = r_mcnt;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      for (int i = 0; i < N; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b01;
      end
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else begin
      if (i_fb_valid && i_fb_branch && w_fb_hit) begin
        r_ctr[w_fi] <= i_fb_feedback_taken ? (&r_ctr[w_fi] ? 2'b11 : r_ctr[w_fi] + 2'b01)
                                           : (|r_ctr[w_fi] ? r_ctr[w_fi] - 2'b01 : 2'b00);
        if (i_fb_feedback_taken) r_target[w_fi] <= i_fb_feedback_target;
      end else if (i_fb_valid && i_fb_branch && i_fb_feedback_taken) begin
        r_valid[w_fi]  <= 1'b1;
        r_tag[w_fi]    <= w_ft;
        r_target[w_fi] <= i_fb_feedback_target;
        r_ctr[w_fi]    <= 2'b10;
      end else if (i_fb_valid && !i_fb_branch && w_fb_hit) begin
        r_valid[w_fi] <= 1'b0;
      end
      if (i_fb_valid && i_fb_branch && !(&r_bcnt)) r_bcnt <= r_bcnt + 1'b1;
      if (o_mispredict && !(&r_mcnt)) r_mcnt <= r_mcnt + 1'b1;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench for branch_predictor; narrow counters make saturation reachable
module tb_branch_predictor;
  localparam int PW = 16;
  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;
  logic clk = 1'b0, n_rst = 1'b0;
  logic [PW-1:0] i_lookup_pc = 16'h0040;
  logic o_predict_taken, o_predict_hit, o_mispredict;
  logic [PW-1:0] o_predict_target, o_redirect_pc;
  logic i_fb_valid = 1'b0, i_fb_branch = 1'b0, i_fb_predict_taken = 1'b0, i_fb_feedback_taken = 1'b0;
  logic [PW-1:0] i_fb_pc = '0, i_fb_predict_target = '0, i_fb_feedback_target = '0;
  logic [CW-1:0] o_branch_count, o_mispredict_count;
  logic [CW-1:0] e_b = '0, e_m = '0;
  int n_chk = 0, n_err = 0;
  typedef struct { string tag; int sel; logic [31:0] exp; } item_t;
  item_t sb[$];

  branch_predictor #(.PC_SIZE(PW), .INDEX_BITS(4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .n_rst(n_rst), .i_lookup_pc(i_lookup_pc),
    .o_predict_taken(o_predict_taken), .o_predict_target(o_predict_target), .o_predict_hit(o_predict_hit),
    .i_fb_valid(i_fb_valid), .i_fb_branch(i_fb_branch), .i_fb_pc(i_fb_pc),
    .i_fb_predict_taken(i_fb_predict_taken), .i_fb_predict_target(i_fb_predict_target),
    .i_fb_feedback_taken(i_fb_feedback_taken), .i_fb_feedback_target(i_fb_feedback_target),
    .o_mispredict(o_mispredict), .o_redirect_pc(o_redirect_pc),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(int s);
    case (s)
      0: obs = 32'(o_predict_hit);
      1: obs = 32'(o_predict_taken);
      2: obs = 32'(o_predict_target);
      3: obs = 32'(o_mispredict);
      4: obs = 32'(o_redirect_pc);
      5: obs = 32'(o_branch_count);
      default: obs = 32'(o_mispredict_count);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb.push_back('{tag, sel, exp});
  endtask

  task automatic drain();
    item_t it;
    #1;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      check(it.tag, obs(it.sel), it.exp);
    end
  endtask

  task automatic push_cnt();
    push("branch_count", 5, 32'(e_b));
    push("mispredict_count", 6, 32'(e_m));
  endtask

  task automatic look(input logic [PW-1:0] pc, input logic h, input logic t, input logic [PW-1:0] tg);
    i_lookup_pc = pc;
    push("hit", 0, 32'(h));
    push("taken", 1, 32'(t));
    push("target", 2, 32'(tg));
    drain();
  endtask

  task automatic send(input logic br, input logic [PW-1:0] pc, input logic pt, input logic [PW-1:0] ptg,
                      input logic ft, input logic [PW-1:0] ftg, input logic em, input logic [PW-1:0] erd);
    @(negedge clk);
    i_fb_valid = 1'b1; i_fb_branch = br; i_fb_pc = pc;
    i_fb_predict_taken = pt; i_fb_predict_target = ptg;
    i_fb_feedback_taken = ft; i_fb_feedback_target = ftg;
    push("mispredict", 3, 32'(em));
    push("redirect", 4, 32'(erd));
    drain();
    if (br && e_b != CMAX) e_b++;
    if (em && e_m != CMAX) e_m++;
    @(negedge clk);
    i_fb_valid = 1'b0;
    push_cnt();
    drain();
  endtask

  initial begin
    #1;
    push_cnt();
    look(16'h0040, 0, 0, 16'h0041);
    @(negedge clk) n_rst = 1'b1;
    send(1, 16'h0043, 0, 16'h0044, 1, 16'h0100, 1, 16'h0100);
    look(16'h0043, 1, 1, 16'h0100);
    send(1, 16'h0043, 1, 16'h0100, 0, 16'h0044, 1, 16'h0044);
    look(16'h0043, 1, 0, 16'h0044);
    send(1, 16'h0043, 0, 16'h0044, 0, 16'h0044, 0, 16'h0044);
    look(16'h0043, 1, 0, 16'h0044);
    send(1, 16'h0043, 0, 16'h0044, 1, 16'h0100, 1, 16'h0100);
    look(16'h0043, 1, 0, 16'h0044);
    send(1, 16'h0043, 0, 16'h0044, 1, 16'h0100, 1, 16'h0100);
    look(16'h0043, 1, 1, 16'h0100);
    send(0, 16'h1043, 0, 16'h1044, 0, 16'h1044, 0, 16'h1044);
    look(16'h0043, 1, 1, 16'h0100);
    look(16'h1043, 0, 0, 16'h1044);
    send(1, 16'h0043, 1, 16'h0100, 1, 16'h0200, 1, 16'h0200);
    look(16'h0043, 1, 1, 16'h0200);
    send(1, 16'h0043, 1, 16'h0200, 1, 16'h0200, 0, 16'h0044);
    send(0, 16'h0077, 1, 16'h0300, 0, 16'h0078, 1, 16'h0078);
    look(16'h0043, 1, 1, 16'h0200);
    send(0, 16'h0043, 0, 16'h0044, 0, 16'h0044, 0, 16'h0044);
    look(16'h0043, 0, 0, 16'h0044);
    @(negedge clk);
    i_fb_branch = 1'b1; i_fb_pc = 16'h0043; i_fb_predict_taken = 1'b0;
    i_fb_feedback_taken = 1'b1; i_fb_feedback_target = 16'h0500;
    push("invalid_mispredict", 3, 0);
    push("invalid_redirect", 4, 32'h0044);
    drain();
    @(negedge clk);
    push_cnt();
    drain();
    look(16'h0043, 0, 0, 16'h0044);
    look(16'hFFFF, 0, 0, 16'h0000);
    send(1, 16'hFFFF, 1, 16'h0005, 0, 16'h0000, 1, 16'h0000);
    look(16'hFFFF, 0, 0, 16'h0000);
    for (int k = 0; k < 20; k++)
      send(1, 16'h0009, 1, 16'h0040, 0, 16'h000A, 1, 16'h000A);
    push("sat_branch", 5, 32'(CMAX));
    push("sat_mispredict", 6, 32'(CMAX));
    drain();
    send(1, 16'h0043, 0, 16'h0044, 1, 16'h0100, 1, 16'h0100);
    look(16'h0043, 1, 1, 16'h0100);
    @(negedge clk);
    i_fb_valid = 1'b1; i_fb_branch = 1'b1; i_fb_pc = 16'h0055; i_fb_predict_taken = 1'b0;
    i_fb_feedback_taken = 1'b1; i_fb_feedback_target = 16'h0600;
    #2 n_rst = 1'b0;
    e_b = '0; e_m = '0;
    push("rst_mispredict", 3, 1);
    push("rst_redirect", 4, 32'h0600);
    push_cnt();
    drain();
    look(16'h0043, 0, 0, 16'h0044);
    @(posedge clk);
    look(16'h0055, 0, 0, 16'h0056);
    push_cnt();
    drain();
    @(negedge clk);
    i_fb_valid = 1'b0;
    n_rst = 1'b1;
    look(16'h0043, 0, 0, 16'h0044);
    look(16'h0055, 0, 0, 16'h0056);
    push_cnt();
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1);
  end
endmodule
